gtp_grs_gen: RTL and testbench
==============================

Name: gtp_grs_gen

Overview:
Global reset generator/conditioner that feeds the device-wide reset net. It synchronizes an asynchronous active-low global reset request and rejects glitches. Accepted requests are stretched into a clean active-low global reset with a guaranteed release hold. The block sits at the top level, beside the clock source, and drives the reset of all functional blocks (MFCC/VQ pipeline etc.).

Parameters:
SYNC_STAGES, 2, synchronizer flop depth on GRS_N (>=2)
FILTER_CYCLES, 4, consecutive synchronized-low cycles needed to accept a request (>=1)
HOLD_CYCLES, 16, synchronized-high cycles grs_n stays low after request release and after local reset (>=1)
CNT_W, 8, width of accepted-request counter

Ports:
clk  in  1  system clock
rst_n  in  1  local reset, synchronous, active-low
GRS_N  in  1  asynchronous active-low global reset request
clr_cnt  in  1  synchronous clear of grs_event_cnt
grs_n  out  1  conditioned global reset, active-low, registered
grs_active  out  1  equals ~grs_n, registered
grs_release  out  1  one-cycle pulse on the cycle grs_n goes 0->1
grs_event_cnt  out  CNT_W  saturating count of accepted requests

Behaviour:
- One clock, clk. rst_n is synchronous and active-low. All state is sampled on the clk rising edge.
- Reset (rst_n=0) values:
  - Synchronizer flops = 1.
  - State = HOLD, hold counter = 0, filter counter = 0.
  - grs_n=0, grs_active=1, grs_release=0, grs_event_cnt=0.
- Synchronizer: GRS_N passes through SYNC_STAGES flops. s = last stage. Only s is used by the FSM.
- FSM; all outputs are registered from the next state:
  - IDLE (grs_n=1): if s=0, go to FILTER with fcnt=1. If FILTER_CYCLES=1, go directly to ASSERT and count the event.
  - FILTER (grs_n=1):
    - s=1: return to IDLE; the glitch is rejected and not counted.
    - s=0 and fcnt=FILTER_CYCLES-1: go to ASSERT and increment grs_event_cnt.
    - Otherwise fcnt++.
  - ASSERT (grs_n=0): stay while s=0. On s=1, go to HOLD with hcnt=1.
  - HOLD (grs_n=0):
    - s=0: go to ASSERT. This is a re-assert and is not counted as a new event.
    - s=1 and hcnt=HOLD_CYCLES-1 (or HOLD_CYCLES=1): go to IDLE and raise grs_release for exactly one cycle.
    - Otherwise hcnt++.
- Latency:
  - Edge 1 is the first edge sampling GRS_N=0. grs_n falls at edge SYNC_STAGES+FILTER_CYCLES (6 with defaults).
  - After s returns high, grs_n rises HOLD_CYCLES edges later.
  - After rst_n deassertion, grs_n rises at the HOLD_CYCLES-th edge with rst_n=1, given GRS_N high long enough to fill the synchronizer.
- Counter:
  - Saturates at 2^CNT_W-1; no wrap.
  - clr_cnt=1 clears it. clr_cnt and an increment in the same cycle give 1.
- Reset mid-operation: rst_n=0 in any state forces the reset values on the next edge. grs_release is never asserted by reset.
- Counter widths are sized from the parameters: $clog2(max+1).

Decomposition:
- Shared package (gtp_grs_pkg): the FSM state typedef {IDLE, FILTER, ASSERT, HOLD} and default constants for SYNC_STAGES, FILTER_CYCLES and HOLD_CYCLES.
- One sub-module: grs_sync, a parameterized SYNC_STAGES-deep flop chain with reset value 1.

Test Plan:
- Power-up: rst_n=0 for 5 cycles, then 1 with GRS_N=1 -> grs_n=0 throughout; grs_n=1 at the 16th edge after release; grs_release pulses one cycle; grs_event_cnt=0.
- Glitch: GRS_N low for 3 cycles -> grs_n stays 1; grs_event_cnt stays 0.
- Accepted request: GRS_N low for 10 cycles -> grs_n=0 at edge 6; count=1; grs_n=1 16 edges after s returns high; one grs_release pulse.
- Re-assert in HOLD: GRS_N low 10 cycles, high 5 cycles, low 10 cycles -> grs_n stays 0 continuously; count=1; single release at the end.
- Saturation/clear:
  - 300 accepted requests -> count=255.
  - clr_cnt pulse -> 0.
  - clr_cnt coincident with an accepting edge -> 1.
- Mid-operation reset: rst_n=0 during ASSERT -> next edge grs_n=0, count=0, state HOLD; no grs_release pulse.

Source files
------------

// File: rtl/gtp_grs_pkg.sv
// gtp_grs_pkg: shared FSM state type and default timing constants for the global reset generator
package gtp_grs_pkg;
    typedef enum logic [1:0] {IDLE, FILTER, ASSERT, HOLD} grs_state_t;
    localparam int SYNC_STAGES_DEF   = 2;
    localparam int FILTER_CYCLES_DEF = 4;
    localparam int HOLD_CYCLES_DEF   = 16;
endpackage

// File: rtl/grs_sync.sv
// grs_sync: flop chain that brings an asynchronous active-low request into the clk domain
module grs_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;
    // Shift the request through the chain; reset to the inactive (high) level
    always_ff @(posedge clk) begin
        if (!rst_n) ff <= '1;
        else        ff <= {ff[STAGES-2:0], d};
    end
    assign q = ff[STAGES-1];
endmodule

// File: rtl/gtp_grs_gen.sv
// gtp_grs_gen: glitch-filtered, stretched global reset with guaranteed release hold
module gtp_grs_gen
    import gtp_grs_pkg::*;
#(
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int FILTER_CYCLES = FILTER_CYCLES_DEF,
    parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             GRS_N,
    input  logic             clr_cnt,
    output logic             grs_n,
    output logic             grs_active,
    output logic             grs_release,
    output logic [CNT_W-1:0] grs_event_cnt
);
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [FW-1:0] F_LAST = FW'(FILTER_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);

    logic             s;
    grs_state_t       state, nxt;
    logic [FW-1:0]    fcnt, fcnt_n;
    logic [HW-1:0]    hcnt, hcnt_n;
    logic             inc, rel;
    logic [CNT_W-1:0] cnt_n;

    grs_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (GRS_N),
        .q     (s)
    );

    // Next-state decode: filter low runs, then hold reset until s stays high long enough
    always_comb begin
        nxt    = state;
        fcnt_n = fcnt;
        hcnt_n = hcnt;
        inc    = 1'b0;
        rel    = 1'b0;
        case (state)
            IDLE: begin
                if (!s) begin
                    if (FILTER_CYCLES == 1) begin
                        nxt = ASSERT;
                        inc = 1'b1;
                    end else begin
                        nxt    = FILTER;
                        fcnt_n = FW'(1);
                    end
                end
            end
            FILTER: begin
                if (s) nxt = IDLE;
                else if (fcnt == F_LAST) begin
                    nxt = ASSERT;
                    inc = 1'b1;
                end else fcnt_n = fcnt + 1'b1;
            end
            ASSERT: begin
                if (s) begin
                    nxt    = HOLD;
                    hcnt_n = HW'(1);
                end
            end
            HOLD: begin
                if (!s) nxt = ASSERT;
                else if (HOLD_CYCLES == 1 || hcnt == H_LAST) begin
                    nxt = IDLE;
                    rel = 1'b1;
                end else hcnt_n = hcnt + 1'b1;
            end
        endcase
    end

    // Clear wins over the old value but still admits a coincident accepted event
    always_comb begin
        cnt_n = clr_cnt ? CNT_W'(inc) : (inc && grs_event_cnt != '1) ? grs_event_cnt + 1'b1 : grs_event_cnt;
    end

    // Register state and drive outputs from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= HOLD;
            fcnt          <= '0;
            hcnt          <= '0;
            grs_n         <= 1'b0;
            grs_active    <= 1'b1;
            grs_release   <= 1'b0;
            grs_event_cnt <= '0;
        end else begin
            state         <= nxt;
            fcnt          <= fcnt_n;
            hcnt          <= hcnt_n;
            grs_n         <= (nxt == IDLE) || (nxt == FILTER);
            grs_active    <= (nxt == ASSERT) || (nxt == HOLD);
            grs_release   <= rel;
            grs_event_cnt <= cnt_n;
        end
    end
endmodule

// File: tb/tb_gtp_grs_gen.sv
// tb_gtp_grs_gen: randomized request bursts checked by an event scoreboard against a run-length model
module tb_gtp_grs_gen;
    localparam int SS = 2;
    localparam int FC = 4;
    localparam int HC = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          GRS_N = 1'b1;
    logic          clr_cnt = 1'b0;
    logic          grs_n;
    logic          grs_active;
    logic          grs_release;
    logic [CW-1:0] grs_event_cnt;

    gtp_grs_gen #(.SYNC_STAGES(SS), .FILTER_CYCLES(FC), .HOLD_CYCLES(HC), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .GRS_N         (GRS_N),
        .clr_cnt       (clr_cnt),
        .grs_n         (grs_n),
        .grs_active    (grs_active),
        .grs_release   (grs_release),
        .grs_event_cnt (grs_event_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rel;
        int edge_no;
        int cnt;
    } ev_t;

    ev_t q[$];
    int  cyc = 0;
    int  pass = 0;
    int  total = 0;
    int  mcnt = 0;
    bit  pend = 0;
    int  rel_edge = 0;
    logic prev_n = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) pass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push_rel(input int e);
        ev_t ev;
        ev.rel = 1; ev.edge_no = e; ev.cnt = 0;
        q.push_back(ev);
    endtask

    task automatic push_acc(input int e, input int c);
        ev_t ev;
        ev.rel = 0; ev.edge_no = e; ev.cnt = c;
        q.push_back(ev);
    endtask

    // Model: the FSM sees the low run on edges a..b; a run reaching an unreleased reset extends it,
    // otherwise a run of at least FC edges is a new accepted request.
    task automatic burst(input int L, input int G, input bit clr);
        int e0, a, b, acc;
        e0  = cyc + 1;
        a   = e0 + SS;
        b   = a + L - 1;
        acc = a + FC - 1;
        if (pend && a <= rel_edge) rel_edge = b + HC;
        else if (L >= FC) begin
            mcnt = clr ? 1 : (mcnt < 255 ? mcnt + 1 : 255);
            push_acc(acc, mcnt);
            rel_edge = b + HC;
            pend = 1;
        end
        if (pend && a + L + G > rel_edge) begin
            push_rel(rel_edge);
            pend = 0;
        end
        for (int i = 0; i < L + G; i++) begin
            GRS_N   = (i < L) ? 1'b0 : 1'b1;
            clr_cnt = clr && (e0 + i == acc);
            step();
        end
        clr_cnt = 1'b0;
    endtask

    // Monitor: every falling edge of grs_n and every release pulse must match the next expected event
    always @(negedge clk) begin
        if (prev_n === 1'b1 && grs_n === 1'b0) begin
            chk("acc_queue", q.size() > 0, 1);
            if (q.size() > 0) begin
                ev_t ev;
                ev = q.pop_front();
                chk("acc_kind", ev.rel, 0);
                chk("acc_edge", cyc, ev.edge_no);
                chk("acc_cnt", int'(grs_event_cnt), ev.cnt);
                chk("acc_active", int'(grs_active), 1);
            end
        end
        if (grs_release === 1'b1) begin
            chk("rel_queue", q.size() > 0, 1);
            if (q.size() > 0) begin
                ev_t ev;
                ev = q.pop_front();
                chk("rel_kind", ev.rel, 1);
                chk("rel_edge", cyc, ev.edge_no);
                chk("rel_rise", {prev_n, grs_n}, 2'b01);
                chk("rel_active", int'(grs_active), 0);
            end
        end
        prev_n <= grs_n;
    end

    initial begin
        int e0;
        repeat (5) step();
        chk("rst_grs_n", int'(grs_n), 0);
        chk("rst_active", int'(grs_active), 1);
        chk("rst_release", int'(grs_release), 0);
        chk("rst_cnt", int'(grs_event_cnt), 0);
        rst_n = 1'b1;
        push_rel(cyc + 1 + HC - 1);
        repeat (25) step();
        burst(3, 20, 0);
        chk("glitch_cnt", int'(grs_event_cnt), 0);
        chk("glitch_grs_n", int'(grs_n), 1);
        burst(10, 20, 0);
        burst(10, 5, 0);
        burst(10, 20, 0);
        chk("reassert_cnt", int'(grs_event_cnt), 2);
        for (int i = 0; i < 40; i++) burst($urandom_range(1, 12), $urandom_range(1, 24), 0);
        for (int i = 0; i < 300; i++) burst(FC, 20, 0);
        chk("sat_cnt", int'(grs_event_cnt), 255);
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        mcnt = 0;
        chk("clr_cnt", int'(grs_event_cnt), 0);
        burst(10, 20, 1);
        chk("clr_inc_cnt", int'(grs_event_cnt), 1);
        e0 = cyc + 1;
        mcnt = mcnt + 1;
        push_acc(e0 + SS + FC - 1, mcnt);
        GRS_N = 1'b0;
        repeat (10) step();
        rst_n = 1'b0;
        step();
        chk("mid_rst_grs_n", int'(grs_n), 0);
        chk("mid_rst_active", int'(grs_active), 1);
        chk("mid_rst_cnt", int'(grs_event_cnt), 0);
        chk("mid_rst_release", int'(grs_release), 0);
        mcnt = 0;
        rst_n = 1'b1;
        GRS_N = 1'b1;
        push_rel(cyc + 1 + HC - 1);
        repeat (30) step();
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
